// File: rtl/write_back_stage.sv
// Final pipeline stage: drives the register-file write port from retiring memory-stage results.
// Latency: 1 cycle for scalar, ALU and scalar-load writes; a vector load commits one cycle after its last beat.
// Backpressure: ready is low while a vector load collects its beats; stall = valid_in & ~ready.
//
// Ports:
//   clk, rst                  - clock (rising edge), asynchronous active-low reset
//   valid_in, WriteRegister_in, WriteRegisterVec_in, SelWriteData, Rd_in, ALUResult
//                             - retiring instruction from the memory stage
//   mem_rdata, mem_beat_valid - memory read data and its beat qualifier
//   ready, stall              - combinational flow control toward earlier stages
//   WRITEREGISTER_WB, WRITEREGISTERVEC_WB, RD_WB, INPUTDATA
//                             - registered register-file write port (strobes are 1-cycle pulses)
module write_back_stage #(
  parameter int BEATS = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_in,
  input  logic         WriteRegister_in,
  input  logic         WriteRegisterVec_in,
  input  logic         SelWriteData,
  input  logic [4:0]   Rd_in,
  input  logic [127:0] ALUResult,
  input  logic [31:0]  mem_rdata,
  input  logic         mem_beat_valid,
  output logic         ready,
  output logic         stall,
  output logic         WRITEREGISTER_WB,
  output logic         WRITEREGISTERVEC_WB,
  output logic [4:0]   RD_WB,
  output logic [127:0] INPUTDATA
);

  localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t          state;
  logic [CW-1:0]   beat_cnt;
  logic [127:0]    asm_buf;
  logic [4:0]      rd_lat;
  logic [127:0]    asm_next;

  assign ready = (state == IDLE);
  assign stall = valid_in & ~ready;

  // Assembly buffer with the current beat dropped into its lane, so the
  // final beat lands in the committed vector on the same edge.
  always_comb begin
    asm_next = asm_buf;
    asm_next[32*beat_cnt +: 32] = mem_rdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state               <= IDLE;
      beat_cnt            <= '0;
      asm_buf             <= '0;
      rd_lat              <= '0;
      WRITEREGISTER_WB    <= 1'b0;
      WRITEREGISTERVEC_WB <= 1'b0;
      RD_WB               <= '0;
      INPUTDATA           <= '0;
    end else begin
      // Strobes are pulses: any edge that does not commit clears them.
      WRITEREGISTER_WB    <= 1'b0;
      WRITEREGISTERVEC_WB <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_in) begin
            if (WriteRegisterVec_in && SelWriteData) begin
              // Vector load: beats follow from the next edge onward.
              rd_lat   <= Rd_in;
              beat_cnt <= '0;
              asm_buf  <= '0;
              state    <= COLLECT;
            end else begin
              RD_WB               <= Rd_in;
              INPUTDATA           <= SelWriteData ? {96'b0, mem_rdata} : ALUResult;
              // Scalar r0 is hardwired; vector v0 is a real register.
              WRITEREGISTER_WB    <= WriteRegister_in && (Rd_in != 5'd0);
              WRITEREGISTERVEC_WB <= WriteRegisterVec_in;
            end
          end
        end
        COLLECT: begin
          if (mem_beat_valid) begin
            asm_buf <= asm_next;
            if (beat_cnt == LAST_BEAT) begin
              INPUTDATA           <= asm_next;
              RD_WB               <= rd_lat;
              WRITEREGISTERVEC_WB <= 1'b1;
              beat_cnt            <= '0;
              state               <= IDLE;
            end else begin
              beat_cnt <= beat_cnt + CW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_write_back_stage.sv
// Self-checking bench for write_back_stage: a scoreboard of expected
// register-file commits checked by a monitor, plus per-scenario inline checks.
module tb_write_back_stage;

  logic         clk = 1'b0;
  logic         rst;
  logic         valid_in;
  logic         WriteRegister_in;
  logic         WriteRegisterVec_in;
  logic         SelWriteData;
  logic [4:0]   Rd_in;
  logic [127:0] ALUResult;
  logic [31:0]  mem_rdata;
  logic         mem_beat_valid;
  logic         ready;
  logic         stall;
  logic         WRITEREGISTER_WB;
  logic         WRITEREGISTERVEC_WB;
  logic [4:0]   RD_WB;
  logic [127:0] INPUTDATA;

  typedef struct packed {
    logic         sc;
    logic         vec;
    logic [4:0]   rd;
    logic [127:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  errors = 0;
  int  checks = 0;

  always #5 clk = ~clk;

  write_back_stage #(.BEATS(4)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .valid_in            (valid_in),
    .WriteRegister_in    (WriteRegister_in),
    .WriteRegisterVec_in (WriteRegisterVec_in),
    .SelWriteData        (SelWriteData),
    .Rd_in               (Rd_in),
    .ALUResult           (ALUResult),
    .mem_rdata           (mem_rdata),
    .mem_beat_valid      (mem_beat_valid),
    .ready               (ready),
    .stall               (stall),
    .WRITEREGISTER_WB    (WRITEREGISTER_WB),
    .WRITEREGISTERVEC_WB (WRITEREGISTERVEC_WB),
    .RD_WB               (RD_WB),
    .INPUTDATA           (INPUTDATA)
  );

  // Commit monitor: every strobe cycle must match the next expected write.
  always @(negedge clk) begin
    wr_t e;
    if (rst && (WRITEREGISTER_WB || WRITEREGISTERVEC_WB)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_commit: got sc=%0b vec=%0b rd=%0d data=%h, required no commit",
                 WRITEREGISTER_WB, WRITEREGISTERVEC_WB, RD_WB, INPUTDATA);
      end else begin
        e = exp_q.pop_front();
        if ({WRITEREGISTER_WB, WRITEREGISTERVEC_WB, RD_WB, INPUTDATA} !== e) begin
          errors++;
          $display("FAIL commit: got sc=%0b vec=%0b rd=%0d data=%h, required sc=%0b vec=%0b rd=%0d data=%h",
                   WRITEREGISTER_WB, WRITEREGISTERVEC_WB, RD_WB, INPUTDATA,
                   e.sc, e.vec, e.rd, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  // Advance one cycle; inputs set afterwards take effect on the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid_in            = 1'b0;
    WriteRegister_in    = 1'b0;
    WriteRegisterVec_in = 1'b0;
    SelWriteData        = 1'b0;
    Rd_in               = 5'd0;
    ALUResult           = '0;
    mem_rdata           = '0;
    mem_beat_valid      = 1'b0;
  endtask

  task automatic drive_instr(input logic wr, input logic wv, input logic sel,
                             input logic [4:0] rd, input logic [127:0] alu,
                             input logic [31:0] md);
    valid_in            = 1'b1;
    WriteRegister_in    = wr;
    WriteRegisterVec_in = wv;
    SelWriteData        = sel;
    Rd_in               = rd;
    ALUResult           = alu;
    mem_rdata           = md;
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if ({WRITEREGISTER_WB, WRITEREGISTERVEC_WB, RD_WB, INPUTDATA, ready} !== {1'b0, 1'b0, 5'd0, 128'd0, 1'b1}) begin
      errors++;
      $display("FAIL %s: got sc=%0b vec=%0b rd=%0d data=%h ready=%0b, required all zero and ready=1",
               name, WRITEREGISTER_WB, WRITEREGISTERVEC_WB, RD_WB, INPUTDATA, ready);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    #12;
    check_reset_outputs("reset_state");
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_stall: got %0b, required 0", stall);
    end
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_scalar_alu();
    logic [127:0] alu;
    alu = {32'hCAFE0001, 32'h0BADF00D, 32'h12345678, 32'hDEADBEEF};
    drive_instr(1'b1, 1'b0, 1'b0, 5'd5, alu, 32'h0);
    exp_q.push_back({1'b1, 1'b0, 5'd5, alu});
    step();
    idle_inputs();
    checks++;
    if ({WRITEREGISTER_WB, RD_WB, INPUTDATA[31:0]} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL scalar_alu: got sc=%0b rd=%0d data=%h, required sc=1 rd=5 data[31:0]=deadbeef",
               WRITEREGISTER_WB, RD_WB, INPUTDATA);
    end
    step();
    checks++;
    if (WRITEREGISTER_WB !== 1'b0) begin
      errors++;
      $display("FAIL scalar_pulse: got %0b, required 0", WRITEREGISTER_WB);
    end
  endtask

  task automatic test_r0();
    drive_instr(1'b1, 1'b0, 1'b0, 5'd0, 128'h77, 32'h0);
    step();
    idle_inputs();
    checks++;
    if (WRITEREGISTER_WB !== 1'b0) begin
      errors++;
      $display("FAIL scalar_r0: got %0b, required 0", WRITEREGISTER_WB);
    end
    // Both enables to r0: only the vector strobe survives.
    drive_instr(1'b1, 1'b1, 1'b0, 5'd0, 128'hA5A5_0000_0000_0000_0000_0000_0000_5A5A, 32'h0);
    exp_q.push_back({1'b0, 1'b1, 5'd0, 128'hA5A5_0000_0000_0000_0000_0000_0000_5A5A});
    step();
    idle_inputs();
    checks++;
    if ({WRITEREGISTER_WB, WRITEREGISTERVEC_WB} !== 2'b01) begin
      errors++;
      $display("FAIL vector_r0: got sc=%0b vec=%0b, required sc=0 vec=1",
               WRITEREGISTER_WB, WRITEREGISTERVEC_WB);
    end
    step();
  endtask

  task automatic test_scalar_load();
    drive_instr(1'b1, 1'b0, 1'b1, 5'd7, {4{32'hFFFF_FFFF}}, 32'h0000_0042);
    exp_q.push_back({1'b1, 1'b0, 5'd7, 128'h42});
    step();
    idle_inputs();
    checks++;
    if ({WRITEREGISTER_WB, RD_WB, INPUTDATA} !== {1'b1, 5'd7, 128'h42}) begin
      errors++;
      $display("FAIL scalar_load: got sc=%0b rd=%0d data=%h, required sc=1 rd=7 data=42",
               WRITEREGISTER_WB, RD_WB, INPUTDATA);
    end
    // Stray beat in IDLE must change nothing.
    mem_rdata      = 32'h9999_9999;
    mem_beat_valid = 1'b1;
    step();
    idle_inputs();
    step();
    checks++;
    if ({ready, INPUTDATA, RD_WB} !== {1'b1, 128'h42, 5'd7}) begin
      errors++;
      $display("FAIL idle_beat: got ready=%0b data=%h rd=%0d, required ready=1 data=42 rd=7",
               ready, INPUTDATA, RD_WB);
    end
  endtask

  task automatic test_vector_load();
    // A beat offered on the accept edge must be ignored.
    drive_instr(1'b0, 1'b1, 1'b1, 5'd3, 128'h0, 32'hBAD0_BAD0);
    mem_beat_valid = 1'b1;
    step();
    idle_inputs();
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL collect_ready: got %0b, required 0", ready);
    end
    mem_rdata = 32'h1111_1111; mem_beat_valid = 1'b1; step();
    mem_rdata = 32'h2222_2222; step();
    mem_beat_valid = 1'b0; mem_rdata = 32'hEEEE_EEEE;
    // Unrelated instruction shows up while collecting: must stall.
    drive_instr(1'b1, 1'b0, 1'b0, 5'd9, 128'h1, 32'hEEEE_EEEE);
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL collect_stall: got %0b, required 1", stall);
    end
    step();
    valid_in = 1'b0;
    step();
    mem_rdata = 32'h3333_3333; mem_beat_valid = 1'b1; step();
    mem_rdata = 32'h4444_4444;
    exp_q.push_back({1'b0, 1'b1, 5'd3, 128'h44444444_33333333_22222222_11111111});
    step();
    idle_inputs();
    checks++;
    if ({WRITEREGISTERVEC_WB, RD_WB, INPUTDATA, ready} !==
        {1'b1, 5'd3, 128'h44444444_33333333_22222222_11111111, 1'b1}) begin
      errors++;
      $display("FAIL vector_load: got vec=%0b rd=%0d data=%h ready=%0b, required vec=1 rd=3 data=44444444333333332222222211111111 ready=1",
               WRITEREGISTERVEC_WB, RD_WB, INPUTDATA, ready);
    end
    step();
    checks++;
    if (WRITEREGISTERVEC_WB !== 1'b0) begin
      errors++;
      $display("FAIL vector_pulse: got %0b, required 0", WRITEREGISTERVEC_WB);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] alu;
    alu = 128'h0000_1234;
    drive_instr(1'b0, 1'b1, 1'b1, 5'd9, 128'h0, 32'h0);
    step();
    // Scalar write held on the inputs for the whole collect phase.
    drive_instr(1'b1, 1'b0, 1'b0, 5'd10, alu, 32'h0);
    mem_beat_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mem_rdata = 32'hA0A0_0000 + 32'(i);
      #1;
      checks++;
      if (stall !== 1'b1) begin
        errors++;
        $display("FAIL b2b_stall beat %0d: got %0b, required 1", i, stall);
      end
      if (i == 3) begin
        exp_q.push_back({1'b0, 1'b1, 5'd9, 128'hA0A00003_A0A00002_A0A00001_A0A00000});
        exp_q.push_back({1'b1, 1'b0, 5'd10, alu});
      end
      step();
    end
    mem_beat_valid = 1'b0;
    checks++;
    if ({WRITEREGISTERVEC_WB, WRITEREGISTER_WB, stall} !== 3'b100) begin
      errors++;
      $display("FAIL b2b_vec_edge: got vec=%0b sc=%0b stall=%0b, required vec=1 sc=0 stall=0",
               WRITEREGISTERVEC_WB, WRITEREGISTER_WB, stall);
    end
    step();
    idle_inputs();
    checks++;
    if ({WRITEREGISTERVEC_WB, WRITEREGISTER_WB, RD_WB} !== {1'b0, 1'b1, 5'd10}) begin
      errors++;
      $display("FAIL b2b_scalar_edge: got vec=%0b sc=%0b rd=%0d, required vec=0 sc=1 rd=10",
               WRITEREGISTERVEC_WB, WRITEREGISTER_WB, RD_WB);
    end
    step();
  endtask

  task automatic test_reset_mid_collect();
    drive_instr(1'b0, 1'b1, 1'b1, 5'd12, 128'h0, 32'h0);
    step();
    idle_inputs();
    mem_beat_valid = 1'b1;
    mem_rdata = 32'h5555_5555; step();
    mem_rdata = 32'h6666_6666; step();
    mem_beat_valid = 1'b0;
    #3;
    rst = 1'b0;
    #1;
    check_reset_outputs("reset_mid_collect");
    step();
    rst = 1'b1;
    // Remaining beats arrive in IDLE and must not complete the old load.
    mem_beat_valid = 1'b1;
    mem_rdata = 32'h7777_7777; step();
    mem_rdata = 32'h8888_8888; step();
    idle_inputs();
    step();
    step();
    checks++;
    if ({WRITEREGISTERVEC_WB, RD_WB, INPUTDATA, ready} !== {1'b0, 5'd0, 128'd0, 1'b1}) begin
      errors++;
      $display("FAIL discard_partial: got vec=%0b rd=%0d data=%h ready=%0b, required vec=0 rd=0 data=0 ready=1",
               WRITEREGISTERVEC_WB, RD_WB, INPUTDATA, ready);
    end
  endtask

  initial begin
    test_reset();
    test_scalar_alu();
    test_r0();
    test_scalar_load();
    test_vector_load();
    test_back_to_back();
    test_reset_mid_collect();
    step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_commits: got %0d pending, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/write_back_stage.md
# write_back_stage

Final pipeline stage of the interpolation ASIP. Takes retired results from the memory stage and produces the register-file write port consumed by instruction decode: `WRITEREGISTER_WB`, `WRITEREGISTERVEC_WB`, `RD_WB`, `INPUTDATA`. Scalar results and scalar loads retire in one cycle. Vector loads arrive as four 32-bit memory beats, so the stage assembles them into one 128-bit vector write and stalls upstream while it does.

## Interface
- Parameters:
- `BEATS`, 4, memory beats per vector load (32-bit beats, 128-bit vector).
- Ports:
- `clk`  in  1  pipeline clock, rising edge.
- `rst`  in  1  asynchronous reset, active-low.
- `valid_in`  in  1  memory stage presents a retiring instruction.
- `WriteRegister_in`  in  1  instruction writes the scalar register file.
- `WriteRegisterVec_in`  in  1  instruction writes the vector register file.
- `SelWriteData`  in  1  write-data source: 0 = ALU result, 1 = memory data.
- `Rd_in`  in  5  destination register.
- `ALUResult`  in  128  ALU result; scalar results occupy [31:0].
- `mem_rdata`  in  32  memory read data.
- `mem_beat_valid`  in  1  `mem_rdata` holds a valid beat this cycle.
- `ready`  out  1  stage can accept `valid_in` this cycle.
- `stall`  out  1  equals `valid_in & ~ready`; routed to earlier stages.
- `WRITEREGISTER_WB`  out  1  scalar register-file write strobe.
- `WRITEREGISTERVEC_WB`  out  1  vector register-file write strobe.
- `RD_WB`  out  5  write address.
- `INPUTDATA`  out  128  write data.

## Operation
- There are two states, IDLE and COLLECT. `ready` is 1 only in IDLE.
- An instruction is accepted on a rising edge when `valid_in & ready`. Decoding on accept:
  - If `WriteRegisterVec_in & SelWriteData` (vector load): latch `Rd_in`, clear the beat counter and the assembly buffer, and go to COLLECT. No strobe is issued yet.
  - Otherwise, register the write directly:
    - `RD_WB` = `Rd_in`.
    - `INPUTDATA` = `ALUResult` when `SelWriteData`=0, or `{96'b0, mem_rdata}` when `SelWriteData`=1 (scalar load; `mem_rdata` is valid in the accept cycle).
    - `WRITEREGISTER_WB` = `WriteRegister_in & (Rd_in != 0)`. Writes to scalar r0 are suppressed.
    - `WRITEREGISTERVEC_WB` = `WriteRegisterVec_in`.
    - If both enables are set, both strobes assert in the same cycle with the same `INPUTDATA`.
- In COLLECT, each edge with `mem_beat_valid` stores `mem_rdata` into lane k, bits [32k+31:32k], where k is the beat counter (0..BEATS-1), and increments the counter.
- On the edge that captures beat BEATS-1:
  - `INPUTDATA` takes the full assembled vector, with the final beat inserted in the same edge.
  - `RD_WB` takes the latched Rd.
  - `WRITEREGISTERVEC_WB` = 1.
  - State returns to IDLE and the counter returns to 0. The counter never wraps past BEATS-1.
- `mem_beat_valid` is ignored in IDLE, including on the accept edge of a vector load.
- `valid_in` is ignored in COLLECT. Upstream holds its instruction while `stall` is high.
- Strobes are single-cycle pulses. Any edge without a commit clears both strobes. `RD_WB` and `INPUTDATA` hold their last value.
- Reset (asserted at any time, including mid-COLLECT):
  - State goes to IDLE and the counter and assembly buffer clear.
  - `WRITEREGISTER_WB`=0, `WRITEREGISTERVEC_WB`=0, `RD_WB`=0, `INPUTDATA`=0, `ready`=1.
  - A partial vector is discarded and never written.

## Timing
- Scalar, ALU-vector and scalar-load paths have 1-cycle latency: accept at edge N, strobe high from edge N to edge N+1. The register file writes on edge N+1.
- Vector load: accept at edge N, with beats on edges N+1 or later. The strobe is high for the one cycle after the 4th-beat edge M.
- At minimum, a vector load takes 1 accept cycle plus 4 beat cycles.
- `ready` rises in the same cycle as the vector strobe, so a new instruction can be accepted back-to-back on edge M+1.
- Gaps between beats (`mem_beat_valid`=0) extend COLLECT with no upper limit. There is no timeout.
- `stall` is combinational from `valid_in` and state; there are no other combinational input-to-output paths.
- All outputs are registered except `ready` and `stall`.

## Test plan
- Reset mid-COLLECT after 2 beats -> all outputs 0 and `ready`=1 immediately; no vector strobe ever appears for that load.
- Scalar ALU write, `Rd_in`=5, `ALUResult`[31:0]=0xDEADBEEF -> one cycle later `WRITEREGISTER_WB`=1, `RD_WB`=5, `INPUTDATA`=0x...DEADBEEF; strobe low the following cycle.
- Scalar write to `Rd_in`=0 -> `WRITEREGISTER_WB` stays 0. Vector write to `Rd_in`=0 -> `WRITEREGISTERVEC_WB`=1.
- Vector load to v3, beats 0x11111111, 0x22222222 (then 2 idle cycles), 0x33333333, 0x44444444 -> single strobe with `RD_WB`=3, `INPUTDATA`=0x44444444_33333333_22222222_11111111; `stall`=1 whenever `valid_in` is high during COLLECT.
- Back-to-back: vector load, then a scalar write presented with `valid_in` held -> the scalar is accepted on the edge after the 4th beat, and its strobe follows the vector strobe by exactly 1 cycle.
- Scalar load, `mem_rdata`=0x00000042, `Rd_in`=7 -> `INPUTDATA`=0x42, `RD_WB`=7, `WRITEREGISTER_WB`=1 after 1 cycle; a `mem_beat_valid` pulse in IDLE has no effect.
